// File: rtl/img_scaler_pkg.sv
// Shared encodings, FSM state type and geometry helper for the image scaler.
package img_scaler_pkg;

  localparam logic [1:0] MODE_REP  = 2'b00;
  localparam logic [1:0] MODE_DEC  = 2'b01;
  localparam logic [1:0] MODE_NEAR = 2'b10;
  localparam logic [1:0] MODE_AVG  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_e;

  // Output width/height for a source dimension: zoom-in multiplies, all else divides.
  function automatic int unsigned out_dim(input int unsigned src, input int unsigned k,
                                          input logic [1:0] mode);
    return (mode == MODE_REP) ? (src << k) : (src >> k);
  endfunction

endpackage

// File: rtl/img_scaler_addr_gen.sv
// Output-pixel / in-block counters and source address generation.
module img_scaler_addr_gen
  import img_scaler_pkg::*;
#(
  parameter int unsigned SRC_W  = 160,
  parameter int unsigned SRC_H  = 120,
  parameter int unsigned K      = 1,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] src_addr_c,
  output logic              first_in_blk_c,
  output logic              last_in_blk_c,
  output logic              last_pix_c
);

  localparam int unsigned F = 1 << K;
  localparam logic [ADDR_W-1:0] OW_UP_M1 = ADDR_W'(out_dim(SRC_W, K, MODE_REP) - 1);
  localparam logic [ADDR_W-1:0] OH_UP_M1 = ADDR_W'(out_dim(SRC_H, K, MODE_REP) - 1);
  localparam logic [ADDR_W-1:0] OW_DN_M1 = ADDR_W'(out_dim(SRC_W, K, MODE_DEC) - 1);
  localparam logic [ADDR_W-1:0] OH_DN_M1 = ADDR_W'(out_dim(SRC_H, K, MODE_DEC) - 1);
  localparam logic [ADDR_W-1:0] SRC_W_A  = ADDR_W'(SRC_W);
  localparam logic [ADDR_W-1:0] HALF_A   = ADDR_W'(F / 2);
  localparam logic [K-1:0]      BLK_M1   = K'(F - 1);

  logic [ADDR_W-1:0] ox, oy;
  logic [K-1:0]      bx, by;
  logic [ADDR_W-1:0] ow_m1, oh_m1;
  logic              is_avg;

  // Per-mode limits, block/pixel flags and the source address of the current read.
  always_comb begin
    ow_m1          = (mode == MODE_REP) ? OW_UP_M1 : OW_DN_M1;
    oh_m1          = (mode == MODE_REP) ? OH_UP_M1 : OH_DN_M1;
    is_avg         = (mode == MODE_AVG);
    last_in_blk_c  = !is_avg || ((bx == BLK_M1) && (by == BLK_M1));
    first_in_blk_c = !is_avg || ((bx == '0) && (by == '0));
    last_pix_c     = (ox == ow_m1) && (oy == oh_m1);
    src_addr_c     = '0;
    case (mode)
      MODE_REP:  src_addr_c = (oy >> K) * SRC_W_A + (ox >> K);
      MODE_DEC:  src_addr_c = (oy << K) * SRC_W_A + (ox << K);
      MODE_NEAR: src_addr_c = ((oy << K) + HALF_A) * SRC_W_A + (ox << K) + HALF_A;
      default:   src_addr_c = ((oy << K) + ADDR_W'(by)) * SRC_W_A + (ox << K) + ADDR_W'(bx);
    endcase
  end

  // Step through the block (average only), then raster order; everything wraps to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ox <= '0;
      oy <= '0;
      bx <= '0;
      by <= '0;
    end else if (advance) begin
      if (!last_in_blk_c) begin
        if (bx == BLK_M1) begin
          bx <= '0;
          by <= by + 1'b1;
        end else begin
          bx <= bx + 1'b1;
        end
      end else begin
        bx <= '0;
        by <= '0;
        if (ox == ow_m1) begin
          ox <= '0;
          oy <= (oy == oh_m1) ? '0 : oy + 1'b1;
        end else begin
          ox <= ox + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/img_scaler.sv
// ROM-to-RAM image scaler: FSM, read/write pipeline, block accumulator and write port.
module img_scaler
  import img_scaler_pkg::*;
#(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned SRC_W  = 160,
  parameter int unsigned SRC_H  = 120,
  parameter int unsigned K      = 1,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [PIX_W-1:0]  ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done
);

  localparam int unsigned F     = 1 << K;
  localparam int unsigned ACC_W = PIX_W + 2 * K;

  state_e            state;
  logic [1:0]        mode_q;
  logic              tail;
  logic              drain_cnt;
  logic [ADDR_W-1:0] wa_cnt;
  logic              v0, wr0, first0;
  logic              v1, wr1, first1;
  logic [ACC_W-1:0]  acc;

  logic              accept_c;
  logic              issue_c;
  logic [1:0]        mode_c;
  logic [ADDR_W-1:0] src_addr_c;
  logic              first_in_blk_c, last_in_blk_c, last_pix_c;
  logic [ACC_W-1:0]  sum_c;
  logic [PIX_W-1:0]  wdata_c;

  // Accept in IDLE/DONE; the address generator sees the incoming mode on that edge.
  always_comb begin
    accept_c = start && ((state == IDLE) || (state == DONE));
    issue_c  = accept_c || ((state == RUN) && !tail);
    mode_c   = accept_c ? mode : mode_q;
  end

  img_scaler_addr_gen #(
    .SRC_W  (SRC_W),
    .SRC_H  (SRC_H),
    .K      (K),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk            (clk),
    .reset          (reset),
    .advance        (issue_c),
    .mode           (mode_c),
    .src_addr_c     (src_addr_c),
    .first_in_blk_c (first_in_blk_c),
    .last_in_blk_c  (last_in_blk_c),
    .last_pix_c     (last_pix_c)
  );

  // Running block sum and the pixel to write (straight copy or truncated mean).
  always_comb begin
    sum_c   = (first1 ? '0 : acc) + ACC_W'(rom_data);
    wdata_c = (mode_q == MODE_AVG) ? PIX_W'(sum_c >> (2 * K)) : rom_data;
  end

  // Source dimensions must divide by the factor for the zoom-out modes.
  always @(posedge clk) begin
    if (!reset && busy && (mode_q != MODE_REP))
      assert (((SRC_W % F) == 0) && ((SRC_H % F) == 0))
        else $error("img_scaler: source size not a multiple of the scale factor");
  end

  // FSM, two-stage read pipeline, accumulator and registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mode_q     <= MODE_REP;
      tail       <= 1'b0;
      drain_cnt  <= 1'b0;
      wa_cnt     <= '0;
      v0         <= 1'b0;
      wr0        <= 1'b0;
      first0     <= 1'b0;
      v1         <= 1'b0;
      wr1        <= 1'b0;
      first1     <= 1'b0;
      acc        <= '0;
      rom_addr   <= '0;
      ram_wraddr <= '0;
      ram_data   <= '0;
      ram_wren   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      v0     <= issue_c;
      wr0    <= last_in_blk_c;
      first0 <= first_in_blk_c;
      if (issue_c) rom_addr <= src_addr_c;

      v1       <= v0;
      wr1      <= v0 && wr0;
      first1   <= first0;
      ram_wren <= v1 && wr1;
      if (v1) begin
        acc <= sum_c;
        if (wr1) begin
          ram_data   <= wdata_c;
          ram_wraddr <= wa_cnt;
          wa_cnt     <= wa_cnt + 1'b1;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= RUN;
            mode_q <= mode;
            tail   <= last_pix_c && last_in_blk_c;
            wa_cnt <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
          end
        end
        RUN: begin
          if (tail) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end else if (last_pix_c && last_in_blk_c) begin
            tail <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state <= DONE;
            tail  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
